// File: rtl/spi_dac_stream.sv
// Streaming driver for AD5543-class serial DACs: accepts samples on a valid/ready
// handshake and shifts each one MSB-first to the selected channel's chip select.
module spi_dac_stream #(
    parameter int DW        = 16,
    parameter int CHN       = 2,
    parameter int CLK_DIV   = 2,
    parameter int FRAME_GAP = 4,
    parameter int CW        = (CHN > 1) ? $clog2(CHN) : 1
) (
    input  logic           aclk,
    input  logic           areset_n,
    input  logic           en,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [DW-1:0]  s_data,
    input  logic [CW-1:0]  s_chan,
    output logic           sclk,
    output logic           sdi,
    output logic [CHN-1:0] cs_n,
    output logic           done,
    output logic           err
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DW);
    localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DW - 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(FRAME_GAP - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    logic [1:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [DW-1:0]    shreg;
    logic             rdy_q;
    logic             chan_legal;
    logic [CHN-1:0]   chan_sel;

    assign s_ready = rdy_q & en;

    // With a single channel the index is ignored and every sample goes to cs_n[0].
    always_comb begin
        chan_sel = '0;
        for (int i = 0; i < CHN; i++) begin
            chan_sel[i] = (CHN == 1) || (int'(s_chan) == i);
        end
        chan_legal = (CHN == 1) || (int'(s_chan) < CHN);
    end

    // done/err are pulses, so a frozen cycle drops them rather than stretching them.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state   <= ST_IDLE;
            rdy_q   <= 1'b0;
            sclk    <= 1'b0;
            sdi     <= 1'b0;
            cs_n    <= '1;
            done    <= 1'b0;
            err     <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            shreg   <= '0;
        end else if (!en) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s_valid && rdy_q) begin
                        rdy_q   <= 1'b0;
                        shreg   <= s_data;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        gap_cnt <= '0;
                        if (chan_legal) begin
                            state <= ST_SHIFT;
                            cs_n  <= ~chan_sel;
                            sdi   <= s_data[DW-1];
                        end else begin
                            state <= ST_GAP;
                            err   <= 1'b1;
                        end
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end

                // The next bit is presented on the falling sclk edge, keeping sdi stable while sclk is high.
                ST_SHIFT: begin
                    if (div_cnt == DIV_MAX) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        if (sclk) begin
                            if (bit_cnt == BIT_MAX) begin
                                state <= ST_HOLD;
                                sdi   <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                sdi     <= shreg[DW-2];
                                shreg   <= shreg << 1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (div_cnt == DIV_MAX) begin
                        div_cnt <= '0;
                        cs_n    <= '1;
                        done    <= 1'b1;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                default: begin
                    if (gap_cnt == GAP_MAX) begin
                        state <= ST_IDLE;
                        rdy_q <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_dac_stream.sv
// Bench for spi_dac_stream: directed frames with literal expectations plus a long
// randomized run checked every cycle against a frame-position model.
module tb_spi_dac_stream;
    localparam int DW        = 16;
    localparam int CHN       = 3;
    localparam int CLK_DIV   = 2;
    localparam int FRAME_GAP = 4;
    localparam int CW        = 2;
    localparam int OW        = 5 + CHN;

    localparam int T_SHIFT   = 2 * DW * CLK_DIV;
    localparam int T_HOLD    = (2 * DW + 1) * CLK_DIV;
    localparam int T_DONE    = T_HOLD + 1;
    localparam int T_END     = T_DONE + FRAME_GAP;
    localparam int T_END_ERR = 1 + FRAME_GAP;
    localparam logic [CHN-1:0] CS_ONE = CHN'(1);

    logic           aclk     = 1'b0;
    logic           areset_n = 1'b0;
    logic           en       = 1'b1;
    logic           s_valid  = 1'b0;
    logic [DW-1:0]  s_data   = '0;
    logic [CW-1:0]  s_chan   = '0;
    logic           s_ready;
    logic           sclk;
    logic           sdi;
    logic [CHN-1:0] cs_n;
    logic           done;
    logic           err;

    int checks   = 0;
    int failures = 0;

    spi_dac_stream #(
        .DW(DW), .CHN(CHN), .CLK_DIV(CLK_DIV), .FRAME_GAP(FRAME_GAP)
    ) dut (
        .aclk(aclk), .areset_n(areset_n), .en(en),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_chan(s_chan),
        .sclk(sclk), .sdi(sdi), .cs_n(cs_n), .done(done), .err(err)
    );

    always #5 aclk = ~aclk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: position m_t within the current frame, advanced only on enabled edges.
    bit            model_live = 1'b0;
    int            m_phase    = 0;
    int            m_t        = 0;
    int            m_chan     = 0;
    int            m_frames   = 0;
    bit            m_legal    = 1'b0;
    bit            m_rdy      = 1'b0;
    bit            m_adv      = 1'b0;
    logic [DW-1:0] m_data     = '0;

    always @(posedge aclk) begin
        if (!areset_n) begin
            model_live = 1'b1;
            m_phase    = 0;
            m_t        = 0;
            m_rdy      = 1'b0;
            m_adv      = 1'b0;
        end else if (!en) begin
            m_adv = 1'b0;
        end else begin
            m_adv = 1'b1;
            if (m_phase == 0) begin
                if (m_rdy && s_valid) begin
                    m_phase = 1;
                    m_t     = 1;
                    m_data  = s_data;
                    m_chan  = int'(s_chan);
                    m_legal = (int'(s_chan) < CHN);
                    m_rdy   = 1'b0;
                    m_frames++;
                end else begin
                    m_rdy = 1'b1;
                end
            end else begin
                m_t++;
                if (m_t == (m_legal ? T_END : T_END_ERR)) begin
                    m_phase = 0;
                    m_rdy   = 1'b1;
                end
            end
        end
    end

    function automatic logic [OW-1:0] modelOutputs();
        logic           e_rdy, e_sclk, e_sdi, e_done, e_err;
        logic [CHN-1:0] e_cs;
        int             k;
        e_rdy  = m_rdy && en;
        e_sclk = 1'b0;
        e_sdi  = 1'b0;
        e_done = 1'b0;
        e_err  = 1'b0;
        e_cs   = '1;
        if (m_phase != 0) begin
            e_rdy = 1'b0;
            if (m_legal) begin
                if (m_t <= T_HOLD) e_cs = ~(CS_ONE << m_chan);
                if (m_t <= T_SHIFT) begin
                    k      = (m_t - 1) / (2 * CLK_DIV);
                    e_sclk = ((m_t - 1) % (2 * CLK_DIV)) >= CLK_DIV;
                    e_sdi  = m_data[DW-1-k];
                end
                if (m_t == T_DONE) e_done = m_adv;
            end else begin
                e_err = (m_t == 1) && m_adv;
            end
        end
        return {e_rdy, e_sclk, e_sdi, e_done, e_err, e_cs};
    endfunction

    always @(negedge aclk) begin
        if (model_live) begin
            checkOutput("model_cycle", 64'({s_ready, sclk, sdi, done, err, cs_n}), 64'(modelOutputs()));
        end
    end

    // Per-cycle capture of a frame, cycle 1 being the first cycle after the handshake edge.
    logic           cap_sclk [0:127];
    logic           cap_sdi  [0:127];
    logic           cap_done [0:127];
    logic           cap_err  [0:127];
    logic           cap_rdy  [0:127];
    logic [CHN-1:0] cap_cs   [0:127];

    task automatic captureCycles(input int n, input int en_lo_at, input int rst_at);
        for (int c = 1; c <= n; c++) begin
            @(negedge aclk);
            cap_sclk[c] = sclk;
            cap_sdi[c]  = sdi;
            cap_done[c] = done;
            cap_err[c]  = err;
            cap_rdy[c]  = s_ready;
            cap_cs[c]   = cs_n;
            @(posedge aclk);
            #1;
            if (en_lo_at != 0 && c == en_lo_at) en = 1'b0;
            if (en_lo_at != 0 && c == en_lo_at + 10) en = 1'b1;
            if (rst_at != 0 && c == rst_at) areset_n = 1'b0;
            if (rst_at != 0 && c == rst_at + 1) areset_n = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] data, input logic [CW-1:0] chan, input bit keep_valid);
        bit got;
        got     = 1'b0;
        s_valid = 1'b1;
        s_data  = data;
        s_chan  = chan;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge aclk);
            if (s_ready) got = 1'b1;
        end
        checkOutput("handshake_wait", 64'(got), 64'(1));
        if (got) begin
            @(posedge aclk);
            #1;
        end
        if (!keep_valid) s_valid = 1'b0;
    endtask

    function automatic int rises(input int n);
        int cnt = 0;
        for (int c = 2; c <= n; c++) if (cap_sclk[c] && !cap_sclk[c-1]) cnt++;
        return cnt;
    endfunction

    function automatic int firstRise(input int n);
        for (int c = 2; c <= n; c++) if (cap_sclk[c] && !cap_sclk[c-1]) return c;
        return -1;
    endfunction

    function automatic int lastRise(input int n);
        int last = -1;
        for (int c = 2; c <= n; c++) if (cap_sclk[c] && !cap_sclk[c-1]) last = c;
        return last;
    endfunction

    function automatic logic [31:0] sdiWord(input int n);
        logic [31:0] w = '0;
        for (int c = 2; c <= n; c++) if (cap_sclk[c] && !cap_sclk[c-1]) w = {w[30:0], cap_sdi[c]};
        return w;
    endfunction

    function automatic int sdiHigh(input int lo, input int hi);
        int cnt = 0;
        for (int c = lo; c <= hi; c++) if (cap_sdi[c]) cnt++;
        return cnt;
    endfunction

    function automatic int doneCount(input int lo, input int hi);
        int cnt = 0;
        for (int c = lo; c <= hi; c++) if (cap_done[c]) cnt++;
        return cnt;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        @(negedge aclk);
        checkOutput("reset_state", 64'({s_ready, sclk, sdi, done, err, cs_n}), 64'(8'b00000_111));
        @(posedge aclk);
        #1;
        areset_n = 1'b1;
        @(negedge aclk);
        checkOutput("ready_release_cycle", 64'(s_ready), 64'(0));
        @(negedge aclk);
        checkOutput("ready_after_release", 64'(s_ready), 64'(1));
        @(posedge aclk);
        #1;

        // Single frame, literal timing and bit pattern.
        applyStimulus(16'hA5C3, 2'd1, 1'b0);
        captureCycles(71, 0, 0);
        checkOutput("t1_cs_first", 64'(cap_cs[1]), 64'(3'b101));
        checkOutput("t1_cs_last", 64'(cap_cs[66]), 64'(3'b101));
        checkOutput("t1_cs_release", 64'(cap_cs[67]), 64'(3'b111));
        checkOutput("t1_done", 64'({cap_done[66], cap_done[67], cap_done[68]}), 64'(3'b010));
        checkOutput("t1_sclk_edges", 64'(rises(71)), 64'(16));
        checkOutput("t1_first_rise", 64'(firstRise(71)), 64'(3));
        checkOutput("t1_last_rise", 64'(lastRise(71)), 64'(63));
        checkOutput("t1_sdi_word", 64'(sdiWord(71)), 64'(16'hA5C3));
        checkOutput("t1_ready", 64'({cap_rdy[70], cap_rdy[71]}), 64'(2'b01));

        // Back-to-back with s_valid held high.
        applyStimulus(16'h0001, 2'd0, 1'b1);
        s_data = 16'h8000;
        s_chan = 2'd1;
        captureCycles(71, 0, 0);
        s_valid = 1'b0;
        checkOutput("t2_ready", 64'({cap_rdy[70], cap_rdy[71]}), 64'(2'b01));
        checkOutput("t2_f1_cs", 64'(cap_cs[1]), 64'(3'b110));
        checkOutput("t2_f1_sdi_high", 64'(sdiHigh(1, 66)), 64'(4));
        checkOutput("t2_f1_bit15", 64'(cap_sdi[61]), 64'(1));
        captureCycles(66, 0, 0);
        checkOutput("t2_f2_cs", 64'(cap_cs[1]), 64'(3'b101));
        checkOutput("t2_f2_sdi_high", 64'(sdiHigh(1, 66)), 64'(4));
        checkOutput("t2_f2_bit0", 64'({cap_sdi[1], cap_sdi[5]}), 64'(2'b10));

        // Enable dropped for ten cycles from cycle 20.
        applyStimulus(16'h3C96, 2'd2, 1'b0);
        captureCycles(80, 19, 0);
        checkOutput("t3_done", 64'({cap_done[76], cap_done[77]}), 64'(2'b01));
        checkOutput("t3_frozen", 64'({cap_sclk[25], cap_sdi[25], cap_cs[25]}),
                    64'({cap_sclk[20], cap_sdi[20], cap_cs[20]}));
        checkOutput("t3_sdi_word", 64'(sdiWord(80)), 64'(16'h3C96));
        checkOutput("t3_sclk_edges", 64'(rises(80)), 64'(16));

        // Reset pulse during cycle 30 of a frame.
        applyStimulus(16'h5A5A, 2'd0, 1'b0);
        captureCycles(40, 0, 29);
        checkOutput("t4_after_reset", 64'({cap_rdy[31], cap_sclk[31], cap_cs[31]}), 64'(5'b00_111));
        checkOutput("t4_ready_again", 64'(cap_rdy[32]), 64'(1));
        checkOutput("t4_no_done", 64'(doneCount(1, 40)), 64'(0));

        // Illegal channel index.
        applyStimulus(16'h1234, 2'd3, 1'b0);
        captureCycles(8, 0, 0);
        checkOutput("t5_err", 64'({cap_err[1], cap_err[2]}), 64'(2'b10));
        checkOutput("t5_cs", 64'(cap_cs[1]), 64'(3'b111));
        checkOutput("t5_no_sclk", 64'(rises(8) + int'(cap_sclk[1])), 64'(0));
        checkOutput("t5_ready", 64'({cap_rdy[4], cap_rdy[5]}), 64'(2'b01));

        // Randomized traffic; the per-cycle model comparison does the checking.
        for (int i = 0; i < 4000; i++) begin
            @(posedge aclk);
            #1;
            en       = ($urandom_range(0, 9) != 0);
            s_valid  = ($urandom_range(0, 3) != 0);
            s_data   = DW'($urandom);
            s_chan   = CW'($urandom_range(0, 3));
            areset_n = ($urandom_range(0, 599) != 0);
        end
        @(posedge aclk);
        #1;
        en       = 1'b1;
        s_valid  = 1'b0;
        areset_n = 1'b1;
        begin
            bit idle_seen;
            idle_seen = 1'b0;
            for (int i = 0; i < 300 && !idle_seen; i++) begin
                @(negedge aclk);
                if (s_ready) idle_seen = 1'b1;
            end
            checkOutput("drain_idle", 64'(idle_seen), 64'(1));
        end
        checkOutput("random_frames_seen", 64'(m_frames >= 25), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_dac_stream.md
Name: spi_dac_stream

Overview:
- Parametrised serial-DAC driver for AD5543-class SPI DACs.
- Successor to the fixed 16-bit, single-channel, divided-clock driver.
- Runs entirely in the aclk domain and generates sclk with an internal divider; no derived clocks.
- Accepts samples over a valid/ready handshake, routes each frame to one of CHN chip selects, and shifts data MSB-first with programmable timing.

Parameters:
- DW, 16: DAC word width in bits; must be ≥ 2.
- CHN, 2: number of DAC channels, i.e. the number of cs_n lines; must be ≥ 1.
- CLK_DIV, 2: aclk cycles per sclk half-period; must be ≥ 1.
- FRAME_GAP, 4: aclk cycles that all cs_n lines stay high after a frame before the next sample is accepted; must be ≥ 1.
- CW, $clog2(CHN) or 1 if CHN==1: channel-index width. Derived; do not override.

Ports:
- aclk  in  1  system clock.
- areset_n  in  1  reset: synchronous, active-low, clock aclk.
- en  in  1  global enable; when low, all state freezes.
- s_valid  in  1  sample valid.
- s_ready  out  1  block can accept a sample.
- s_data  in  DW  sample word, two's complement passed through unmodified.
- s_chan  in  CW  target channel index.
- sclk  out  1  serial clock; idles low.
- sdi  out  1  serial data.
- cs_n  out  CHN  per-channel chip select, active-low.
- done  out  1  one-cycle pulse when a frame's cs_n deasserts.
- err  out  1  one-cycle pulse when a sample with an illegal channel is accepted.

Behaviour:
- Reset values on the aclk edge with areset_n=0:
  - state IDLE; s_ready=0; sclk=0; sdi=0; cs_n all ones; done=0; err=0; all counters 0.
  - s_ready rises on the first cycle after reset is released, provided en=1.
- FSM states: IDLE, SHIFT, HOLD, GAP.
- IDLE:
  - s_ready = en.
  - Handshake occurs on an edge where s_valid & s_ready. The block latches s_data into the shift register and latches s_chan.
  - Legal channel (s_chan < CHN): go to SHIFT.
  - Illegal channel (s_chan ≥ CHN): pulse err next cycle, assert no cs_n, go to GAP.
- Frame timing is counted in aclk cycles; cycle 1 is the first cycle after the handshake edge. Let D = CLK_DIV.
- SHIFT:
  - cs_n[chan]=0 from cycle 1.
  - Bit k (k = 0..DW-1) occupies cycles 2kD+1 .. 2(k+1)D.
  - Within bit k: sclk=0 for the first D cycles and 1 for the last D cycles; sdi = data[DW-1-k] throughout.
  - sdi changes only while sclk is low.
- HOLD:
  - Cycles 2DW·D+1 .. (2DW+1)D, with sclk=0, sdi=0, cs_n[chan]=0.
- Deassert:
  - At cycle (2DW+1)D+1: cs_n all high, done=1 for one cycle, go to GAP.
  - The DAC latches its word on this cs_n rising edge.
- GAP:
  - Lasts FRAME_GAP cycles with s_ready=0, then IDLE.
  - s_ready is high again at cycle (2DW+1)D+1+FRAME_GAP.
- Output constraints:
  - At most one cs_n bit is low at any time.
  - sclk toggles only while some cs_n is low.
  - s_ready is never high outside IDLE.
- en=0:
  - FSM, bit counter, divider counter and shift register hold.
  - Outputs hold their current values; no handshake occurs (s_ready=0); done/err are not generated.
  - Resuming continues exactly where the block stopped.
- Reset mid-frame:
  - The next edge forces all reset values: cs_n high immediately, no done pulse, and the partial frame is discarded.
- Back-to-back: with s_valid held high, a new handshake occurs on the first IDLE cycle. The frame period is (2DW+1)D+1+FRAME_GAP cycles.
- Data independence: s_data and s_chan are sampled only at the handshake; later changes have no effect.
- CHN==1: s_chan is ignored, always channel 0, and err never fires.

Test Plan:
- Defaults (DW=16, D=2, FRAME_GAP=4), send s_data=16'hA5C3, s_chan=1 → cs_n=2'b01 for cycles 1–66; sclk rising at cycles 3,7,…,63 (16 edges); sdi sequence 1010_0101_1100_0011; cs_n=2'b11 and done=1 at cycle 67; s_ready=1 at cycle 71.
- s_valid held high, samples 16'h0001 (chan 0) then 16'h8000 (chan 1) → second handshake at cycle 71; first frame shows sdi high only during bit 15, second only during bit 0; cs_n[0] and cs_n[1] never low together.
- en forced low for 10 cycles at cycle 20 of a frame → all outputs frozen for those 10 cycles; done arrives at cycle 77; the sdi bit pattern is intact.
- areset_n=0 for 1 cycle at cycle 30 of a frame → cs_n=all ones, sclk=0, s_ready=0 next edge; no done; s_ready=1 one cycle after release.
- CHN=3, s_chan=3 → err pulse at cycle 1; cs_n stays 3'b111; sclk stays 0; s_ready returns at cycle 1+FRAME_GAP.
- DW=12, D=1, FRAME_GAP=1, data 12'hFFF → 12 sclk rising edges at cycles 2,4,…,24; sdi=1 for cycles 1–24; cs_n high and done=1 at cycle 26; s_ready=1 at cycle 27.
